// File: rtl/a_repeat_pkg.sv
// Shared types, limits and the parameter legality check for the a-run responder.
package a_repeat_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, ACK, DATA} resp_state_e;

  localparam int MAX_RUN     = 2;
  localparam int ACK_DLY_MIN = 2;
  localparam int ACK_DLY_MAX = 3;
  localparam int C_LEN_MIN   = 1;
  localparam int C_LEN_MAX   = 2;
  localparam int CNT_W_DEF   = 8;

  function automatic bit params_ok(input int ack_dly, input int c_len, input int cnt_w);
    return (ack_dly >= ACK_DLY_MIN) && (ack_dly <= ACK_DLY_MAX) &&
           (c_len >= C_LEN_MIN) && (c_len <= C_LEN_MAX) && (cnt_w >= 1);
  endfunction

endpackage

// File: rtl/a_repeat_responder_sat_cnt.sv
// Saturating event counter: holds at all-ones instead of wrapping.
module sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else if (inc && (q_q != '1)) begin
      q_q <= q_q + W'(1);
    end
  end

  assign q = q_q;

endmodule

// File: rtl/a_repeat_responder.sv
// Responder for the a-run request handshake: one-cycle b a fixed delay after
// the first a, then c for C_LEN cycles, with run/collision error reporting.
module a_repeat_responder
  import a_repeat_pkg::*;
#(
  parameter int ACK_DLY = 2,
  parameter int C_LEN   = 2,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  output logic             b,
  output logic             c,
  output logic             busy,
  output logic             err_run,
  output logic             drop,
  output logic [CNT_W-1:0] req_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam logic [1:0] ACK_LAST = 2'(ACK_DLY - 1);
  localparam logic [1:0] C_LAST   = 2'(C_LEN - 1);
  localparam logic [1:0] RUN_MAX  = 2'(MAX_RUN);

  if (!params_ok(ACK_DLY, C_LEN, CNT_W)) begin : g_param_err
    $error("a_repeat_responder: illegal ACK_DLY/C_LEN/CNT_W");
  end

  resp_state_e state_q;
  logic [1:0]  dly_cnt_q, c_cnt_q, run_len_q;
  logic        run_open_q;
  logic        b_q, c_q, busy_q, err_run_q, drop_q;

  logic data_done, accept, err_run_d, drop_d, drop_inc;

  // The last DATA edge doubles as an IDLE edge so a back-to-back request has no bubble.
  always_comb begin
    data_done = (state_q == DATA) && (c_cnt_q == C_LAST);
    accept    = a && ((state_q == IDLE) || data_done);
    err_run_d = a && run_open_q && (run_len_q == RUN_MAX) && (state_q != IDLE);
    drop_d    = a && !run_open_q && (state_q != IDLE) && !data_done;
    drop_inc  = err_run_d || drop_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      dly_cnt_q  <= '0;
      c_cnt_q    <= '0;
      run_len_q  <= '0;
      run_open_q <= 1'b0;
      b_q        <= 1'b0;
      c_q        <= 1'b0;
      busy_q     <= 1'b0;
      err_run_q  <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      b_q       <= 1'b0;
      c_q       <= 1'b0;
      err_run_q <= err_run_d;
      drop_q    <= drop_d;

      // Run tracking spans states: a third a may land while already in ACK.
      if (accept) begin
        run_open_q <= 1'b1;
        run_len_q  <= 2'd1;
      end else if (!a) begin
        run_open_q <= 1'b0;
      end else if (run_open_q) begin
        if (run_len_q < RUN_MAX) run_len_q <= run_len_q + 2'd1;
        else                     run_open_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (a) begin
            state_q   <= WAIT;
            dly_cnt_q <= 2'd1;
            busy_q    <= 1'b1;
          end
        end
        WAIT: begin
          dly_cnt_q <= dly_cnt_q + 2'd1;
          if (dly_cnt_q == ACK_LAST) begin
            state_q <= ACK;
            b_q     <= 1'b1;
          end
        end
        ACK: begin
          state_q <= DATA;
          c_cnt_q <= '0;
          c_q     <= 1'b1;
        end
        DATA: begin
          if (data_done) begin
            if (a) begin
              state_q   <= WAIT;
              dly_cnt_q <= 2'd1;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            c_cnt_q <= c_cnt_q + 2'd1;
            c_q     <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign b       = b_q;
  assign c       = c_q;
  assign busy    = busy_q;
  assign err_run = err_run_q;
  assign drop    = drop_q;

  sat_cnt #(.W(CNT_W)) u_req_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (accept),
    .q     (req_cnt)
  );

  sat_cnt #(.W(CNT_W)) u_drop_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (drop_inc),
    .q     (drop_cnt)
  );

endmodule

// File: tb/tb_a_repeat_responder.sv
// Directed vector bench: default-parameter instance plus an ACK_DLY=3/C_LEN=1/CNT_W=2 instance.
module tb_a_repeat_responder;

  typedef struct {
    logic a;
    logic b;
    logic c;
    logic busy;
    logic err;
    logic drop;
    int   req;
    int   dc;
  } vec_t;

  logic clk, rst_n;
  logic a0, b0, c0, busy0, err0, drop0;
  logic [7:0] req0, dc0;
  logic a1, b1, c1, busy1, err1, drop1;
  logic [1:0] req1, dc1;

  int n_vec, n_bad;
  vec_t tab0[28];
  vec_t tab1[30];

  a_repeat_responder #(.ACK_DLY(2), .C_LEN(2), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .a(a0), .b(b0), .c(c0), .busy(busy0),
    .err_run(err0), .drop(drop0), .req_cnt(req0), .drop_cnt(dc0)
  );

  a_repeat_responder #(.ACK_DLY(3), .C_LEN(1), .CNT_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .c(c1), .busy(busy1),
    .err_run(err1), .drop(drop1), .req_cnt(req1), .drop_cnt(dc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic a, input logic b, input logic c, input logic busy,
                              input logic err, input logic drop, input int req, input int dc);
    vec_t v;
    v.a = a; v.b = b; v.c = c; v.busy = busy; v.err = err; v.drop = drop;
    v.req = req; v.dc = dc;
    return v;
  endfunction

  task automatic check_vec(input int which, input string name, input int idx, input vec_t v);
    vec_t g;
    if (which == 0) g = mk(a0, b0, c0, busy0, err0, drop0, int'(req0), int'(dc0));
    else            g = mk(a1, b1, c1, busy1, err1, drop1, int'(req1), int'(dc1));
    n_vec++;
    if (g.b !== v.b || g.c !== v.c || g.busy !== v.busy || g.err !== v.err ||
        g.drop !== v.drop || g.req != v.req || g.dc != v.dc) begin
      n_bad++;
      $display("FAIL %s[%0d] got b=%0b c=%0b busy=%0b err=%0b drop=%0b req=%0d dc=%0d, want b=%0b c=%0b busy=%0b err=%0b drop=%0b req=%0d dc=%0d",
               name, idx, g.b, g.c, g.busy, g.err, g.drop, g.req, g.dc,
               v.b, v.c, v.busy, v.err, v.drop, v.req, v.dc);
    end
  endtask

  // Row i: a driven for posedge i, and the outputs expected to be sampled at posedge i.
  task automatic run_table(input int which);
    int n;
    n = (which == 0) ? 28 : 30;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (which == 0) begin
        check_vec(0, "dflt", i, tab0[i]);
        a0 = tab0[i].a;
      end else begin
        check_vec(1, "d3c1", i, tab1[i]);
        a1 = tab1[i].a;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t zero;
    n_vec = 0;
    n_bad = 0;
    zero  = mk(0, 0, 0, 0, 0, 0, 0, 0);

    // single request, back-to-back, busy collision, over-long run
    tab0[0]  = mk(1,0,0,0,0,0,0,0); tab0[1]  = mk(0,0,0,1,0,0,1,0);
    tab0[2]  = mk(0,1,0,1,0,0,1,0); tab0[3]  = mk(0,0,1,1,0,0,1,0);
    tab0[4]  = mk(0,0,1,1,0,0,1,0); tab0[5]  = mk(0,0,0,0,0,0,1,0);
    tab0[6]  = mk(1,0,0,0,0,0,1,0); tab0[7]  = mk(0,0,0,1,0,0,2,0);
    tab0[8]  = mk(0,1,0,1,0,0,2,0); tab0[9]  = mk(0,0,1,1,0,0,2,0);
    tab0[10] = mk(1,0,1,1,0,0,2,0); tab0[11] = mk(0,0,0,1,0,0,3,0);
    tab0[12] = mk(0,1,0,1,0,0,3,0); tab0[13] = mk(0,0,1,1,0,0,3,0);
    tab0[14] = mk(0,0,1,1,0,0,3,0); tab0[15] = mk(0,0,0,0,0,0,3,0);
    tab0[16] = mk(1,0,0,0,0,0,3,0); tab0[17] = mk(0,0,0,1,0,0,4,0);
    tab0[18] = mk(0,1,0,1,0,0,4,0); tab0[19] = mk(1,0,1,1,0,0,4,0);
    tab0[20] = mk(0,0,1,1,0,1,4,1); tab0[21] = mk(0,0,0,0,0,0,4,1);
    tab0[22] = mk(1,0,0,0,0,0,4,1); tab0[23] = mk(1,0,0,1,0,0,5,1);
    tab0[24] = mk(1,1,0,1,0,0,5,1); tab0[25] = mk(0,0,1,1,1,0,5,2);
    tab0[26] = mk(0,0,1,1,0,0,5,2); tab0[27] = mk(0,0,0,0,0,0,5,2);

    // two-cycle run, drop in WAIT, back-to-back, saturation of both 2-bit counters
    tab1[0]  = mk(1,0,0,0,0,0,0,0); tab1[1]  = mk(1,0,0,1,0,0,1,0);
    tab1[2]  = mk(0,0,0,1,0,0,1,0); tab1[3]  = mk(0,1,0,1,0,0,1,0);
    tab1[4]  = mk(0,0,1,1,0,0,1,0); tab1[5]  = mk(1,0,0,0,0,0,1,0);
    tab1[6]  = mk(0,0,0,1,0,0,2,0); tab1[7]  = mk(1,0,0,1,0,0,2,0);
    tab1[8]  = mk(0,1,0,1,0,1,2,1); tab1[9]  = mk(0,0,1,1,0,0,2,1);
    tab1[10] = mk(1,0,0,0,0,0,2,1); tab1[11] = mk(0,0,0,1,0,0,3,1);
    tab1[12] = mk(0,0,0,1,0,0,3,1); tab1[13] = mk(0,1,0,1,0,0,3,1);
    tab1[14] = mk(1,0,1,1,0,0,3,1); tab1[15] = mk(0,0,0,1,0,0,3,1);
    tab1[16] = mk(0,0,0,1,0,0,3,1); tab1[17] = mk(0,1,0,1,0,0,3,1);
    tab1[18] = mk(0,0,1,1,0,0,3,1); tab1[19] = mk(1,0,0,0,0,0,3,1);
    tab1[20] = mk(1,0,0,1,0,0,3,1); tab1[21] = mk(1,0,0,1,0,0,3,1);
    tab1[22] = mk(0,1,0,1,1,0,3,2); tab1[23] = mk(0,0,1,1,0,0,3,2);
    tab1[24] = mk(1,0,0,0,0,0,3,2); tab1[25] = mk(0,0,0,1,0,0,3,2);
    tab1[26] = mk(1,0,0,1,0,0,3,2); tab1[27] = mk(1,1,0,1,0,1,3,3);
    tab1[28] = mk(0,0,1,1,0,1,3,3); tab1[29] = mk(0,0,0,0,0,0,3,3);

    rst_n = 1'b0;
    a0 = 1'b0;
    a1 = 1'b0;
    repeat (3) @(negedge clk);
    check_vec(0, "rst0", 0, zero);
    check_vec(1, "rst1", 0, zero);
    rst_n = 1'b1;

    run_table(0);
    run_table(1);

    // reset in the middle of a transaction
    @(negedge clk);
    a0 = 1'b1;
    @(negedge clk);
    a0 = 1'b0;
    check_vec(0, "pre_rst", 0, mk(0,0,0,1,0,0,6,2));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_vec(0, "mid_rst", 0, zero);
    check_vec(1, "mid_rst1", 0, zero);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_vec(0, "post_rst", i, zero);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
